// File: rtl/calc_operand_regs.sv
// rtl/calc_operand_regs.sv - keypad calculator operand/entry registers with arithmetic-unit handshake
module calc_operand_regs #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 64,
    localparam int W      = 4 * DIGITS,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          newhex,
    input  logic [3:0]    hexcode,
    input  logic          newop,
    input  logic [1:0]    opcode,
    input  logic          eq,
    input  logic          bksp,
    input  logic          clr,
    input  logic [W-1:0]  ans,
    input  logic          ans_valid,
    output logic [W-1:0]  v1_reg,
    output logic [W-1:0]  v2_reg,
    output logic [1:0]    op_reg,
    output logic          calc_req,
    output logic          busy,
    output logic [CW-1:0] digit_count,
    output logic          err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);
    localparam logic [TW-1:0] LAST_T  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        FRESH    = 2'd0,
        ENTRY    = 2'd1,
        WAIT_ANS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  v1_q, v1_d, v2_q, v2_d;
    logic [1:0]    op_q, op_d, next_op_q, next_op_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d, chain_q, chain_d;
    logic          err_q, err_d, calc_req_q, calc_req_d, busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        op_d       = op_q;
        next_op_d  = next_op_q;
        count_d    = count_q;
        timer_d    = timer_q;
        pending_d  = pending_q;
        chain_d    = chain_q;
        err_d      = err_q;

        if (clr) begin
            v1_d      = '0;
            v2_d      = '0;
            op_d      = '0;
            count_d   = '0;
            pending_d = 1'b0;
            chain_d   = 1'b0;
            err_d     = 1'b0;
            timer_d   = '0;
            state_d   = FRESH;
        end else if (state_q == WAIT_ANS) begin
            // Key strobes are dropped here; only the answer or the timer moves us on.
            if (ans_valid) begin
                v1_d    = ans;
                count_d = '0;
                state_d = FRESH;
                if (chain_q) begin
                    v2_d = ans;
                    op_d = next_op_q;
                end else begin
                    pending_d = 1'b0;
                end
            end else if (timer_q == LAST_T) begin
                err_d     = 1'b1;
                pending_d = 1'b0;
                state_d   = FRESH;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else if (eq) begin
            if (pending_q) begin
                chain_d = 1'b0;
                timer_d = '0;
                state_d = WAIT_ANS;
            end else begin
                state_d = FRESH;
            end
        end else if (newop) begin
            if (!pending_q || state_q == FRESH) begin
                v2_d      = v1_q;
                op_d      = opcode;
                pending_d = 1'b1;
                count_d   = '0;
                state_d   = FRESH;
            end else begin
                next_op_d = opcode;
                chain_d   = 1'b1;
                timer_d   = '0;
                state_d   = WAIT_ANS;
            end
        end else if (bksp) begin
            if (state_q == ENTRY) begin
                v1_d    = v1_q >> 4;
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = FRESH;
                end
            end
        end else if (newhex) begin
            if (state_q == FRESH) begin
                v1_d    = W'(hexcode);
                count_d = CW'(1);
                state_d = ENTRY;
            end else if (count_q != MAX_CNT) begin
                v1_d    = (v1_q << 4) | W'(hexcode);
                count_d = count_q + 1'b1;
            end
        end

        calc_req_d = (state_d == WAIT_ANS) && (state_q != WAIT_ANS);
        busy_d     = (state_d == WAIT_ANS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FRESH;
            v1_q       <= '0;
            v2_q       <= '0;
            op_q       <= '0;
            next_op_q  <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            pending_q  <= 1'b0;
            chain_q    <= 1'b0;
            err_q      <= 1'b0;
            calc_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            op_q       <= op_d;
            next_op_q  <= next_op_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            chain_q    <= chain_d;
            err_q      <= err_d;
            calc_req_q <= calc_req_d;
            busy_q     <= busy_d;
        end
    end

    assign v1_reg      = v1_q;
    assign v2_reg      = v2_q;
    assign op_reg      = op_q;
    assign calc_req    = calc_req_q;
    assign busy        = busy_q;
    assign digit_count = count_q;
    assign err         = err_q;

endmodule

// File: tb/tb_calc_operand_regs.sv
// tb/tb_calc_operand_regs.sv - self-checking bench for calc_operand_regs
module tb_calc_operand_regs;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 8;
    localparam int W       = 16;
    localparam int CW      = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          newhex = 1'b0, newop = 1'b0, eq = 1'b0, bksp = 1'b0, clr = 1'b0, ans_valid = 1'b0;
    logic [3:0]    hexcode = '0;
    logic [1:0]    opcode = '0;
    logic [W-1:0]  ans = '0;
    logic [W-1:0]  v1_reg, v2_reg;
    logic [1:0]    op_reg;
    logic          calc_req, busy, err;
    logic [CW-1:0] digit_count;

    always #5 clock = ~clock;

    calc_operand_regs #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .newhex(newhex), .hexcode(hexcode),
        .newop(newop), .opcode(opcode), .eq(eq), .bksp(bksp), .clr(clr),
        .ans(ans), .ans_valid(ans_valid), .v1_reg(v1_reg), .v2_reg(v2_reg),
        .op_reg(op_reg), .calc_req(calc_req), .busy(busy),
        .digit_count(digit_count), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: calculator behaviour described directly in arithmetic terms.
    int m_v1 = 0, m_v2 = 0, m_op = 0, m_cnt = 0, m_err = 0, m_req = 0;
    bit m_pending = 0, m_chain = 0, m_waiting = 0, m_fresh = 1;
    int m_next_op = 0, m_age = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input bit nh, input int hc, input bit no, input int oc,
                         input bit e, input bit b, input bit c, input int a, input bit av);
        m_req = 0;
        if (c) begin
            m_v1 = 0; m_v2 = 0; m_op = 0; m_cnt = 0; m_err = 0;
            m_pending = 0; m_chain = 0; m_waiting = 0; m_fresh = 1;
        end else if (m_waiting) begin
            if (av) begin
                m_v1 = a; m_cnt = 0; m_waiting = 0; m_fresh = 1;
                if (m_chain) begin m_v2 = a; m_op = m_next_op; end
                else m_pending = 0;
            end else begin
                m_age++;
                if (m_age == TIMEOUT) begin
                    m_err = 1; m_pending = 0; m_waiting = 0; m_fresh = 1;
                end
            end
        end else if (e) begin
            if (m_pending) begin
                m_chain = 0; m_waiting = 1; m_age = 0; m_req = 1;
            end else m_fresh = 1;
        end else if (no) begin
            if (!m_pending || m_fresh) begin
                m_v2 = m_v1; m_op = oc; m_pending = 1; m_cnt = 0; m_fresh = 1;
            end else begin
                m_next_op = oc; m_chain = 1; m_waiting = 1; m_age = 0; m_req = 1;
            end
        end else if (b) begin
            if (!m_fresh) begin
                m_v1 = m_v1 / 16; m_cnt--;
                if (m_cnt == 0) m_fresh = 1;
            end
        end else if (nh) begin
            if (m_fresh) begin
                m_v1 = hc; m_cnt = 1; m_fresh = 0;
            end else if (m_cnt < DIGITS) begin
                m_v1 = (m_v1 * 16 + hc) % (1 << W); m_cnt++;
            end
        end
    endtask

    task automatic step(input bit nh, input logic [3:0] hc, input bit no, input logic [1:0] oc,
                        input bit e, input bit b, input bit c, input logic [W-1:0] a, input bit av);
        newhex = nh; hexcode = hc; newop = no; opcode = oc; eq = e; bksp = b; clr = c;
        ans = a; ans_valid = av;
        model(nh, int'(hc), no, int'(oc), e, b, c, int'(a), av);
        @(posedge clock);
        #1;
        newhex = 0; newop = 0; eq = 0; bksp = 0; clr = 0; ans_valid = 0;
        chk("model_v1", v1_reg, m_v1);
        chk("model_v2", v2_reg, m_v2);
        chk("model_op", op_reg, m_op);
        chk("model_cnt", digit_count, m_cnt);
        chk("model_req", calc_req, m_req);
        chk("model_busy", busy, m_waiting);
        chk("model_err", err, m_err);
    endtask

    task automatic key(input logic [3:0] h);  step(1, h, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic opk(input logic [1:0] o);  step(0, 0, 1, o, 0, 0, 0, 0, 0); endtask
    task automatic eqk();                     step(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic clrk();                    step(0, 0, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic idle();                    step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic ansv(input logic [W-1:0] a); step(0, 0, 0, 0, 0, 0, 0, a, 1); endtask

    typedef struct {
        bit          nh;
        logic [3:0]  hc;
        bit          bk;
        bit          cl;
        logic [W-1:0] e_v1;
        int          e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 0};
        tbl[1]  = '{1'b1, 4'h1, 1'b0, 1'b0, 16'h0001, 1};
        tbl[2]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0012, 2};
        tbl[3]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'h0123, 3};
        tbl[4]  = '{1'b1, 4'h4, 1'b0, 1'b0, 16'h1234, 4};
        tbl[5]  = '{1'b1, 4'h5, 1'b0, 1'b0, 16'h1234, 4};
        tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 0};
        tbl[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 16'h0001, 1};
        tbl[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 16'h0012, 2};
        tbl[9]  = '{1'b1, 4'h3, 1'b0, 1'b0, 16'h0123, 3};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'h0012, 2};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'h0001, 1};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 0};
        tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 0};
        tbl[14] = '{1'b1, 4'h7, 1'b0, 1'b0, 16'h0007, 1};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_v1", v1_reg, 0);
        chk("reset_v2", v2_reg, 0);
        chk("reset_op", op_reg, 0);
        chk("reset_req", calc_req, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cnt", digit_count, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].nh, tbl[i].hc, 0, 0, 0, tbl[i].bk, tbl[i].cl, 0, 0);
            chk($sformatf("tbl%0d_v1", i), v1_reg, tbl[i].e_v1);
            chk($sformatf("tbl%0d_cnt", i), digit_count, tbl[i].e_cnt);
        end

        // Single operation with a three-cycle answer latency.
        clrk(); key(1); key(2); opk(1);
        chk("op_v2", v2_reg, 16'h0012);
        chk("op_reg", op_reg, 1);
        chk("op_cnt", digit_count, 0);
        key(3); eqk();
        chk("eq_req", calc_req, 1);
        chk("eq_busy", busy, 1);
        idle();
        chk("eq_req_once", calc_req, 0);
        chk("eq_busy_hold", busy, 1);
        idle(); ansv(16'h0015);
        chk("ans_v1", v1_reg, 16'h0015);
        chk("ans_busy", busy, 0);
        eqk();
        chk("eq_no_pending", busy, 0);

        // Chained operation.
        clrk(); key(5); opk(0); key(3); opk(2);
        chk("chain_busy", busy, 1);
        chk("chain_req", calc_req, 1);
        ansv(16'h0008);
        chk("chain_v1", v1_reg, 16'h0008);
        chk("chain_v2", v2_reg, 16'h0008);
        chk("chain_op", op_reg, 2);
        chk("chain_busy_done", busy, 0);
        key(2);
        chk("chain_next_v1", v1_reg, 16'h0002);

        // Timeout.
        clrk(); key(1); opk(1); key(2); eqk();
        repeat (TIMEOUT - 1) idle();
        chk("to_busy_before", busy, 1);
        chk("to_err_before", err, 0);
        idle();
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        chk("to_v1", v1_reg, 16'h0002);
        clrk();
        chk("to_err_clr", err, 0);

        // Priority and abort.
        clrk(); key(1); opk(0); key(2);
        step(1, 4'h9, 0, 0, 1, 0, 0, 0, 0);
        chk("prio_busy", busy, 1);
        chk("prio_v1", v1_reg, 16'h0002);
        clrk();
        chk("abort_busy", busy, 0);
        ansv(16'hABCD);
        chk("late_v1", v1_reg, 0);
        chk("late_v2", v2_reg, 0);
        chk("late_busy", busy, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit c, e, no, b, nh, av;
            r  = $urandom_range(0, 99);
            c  = (r < 2);
            e  = (r >= 2 && r < 10);
            no = (r >= 10 && r < 20);
            b  = (r >= 20 && r < 32);
            nh = (r >= 32 && r < 65) || ($urandom_range(0, 9) == 0);
            av = ($urandom_range(0, 5) == 0);
            step(nh, 4'($urandom), no, 2'($urandom), e, b, c, 16'($urandom), av);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
